// File: rtl/sr_chk_pkg.sv
// Shared definitions for the PRBS7 serial checker: state encoding, LFSR taps,
// counter widths and saturating increment helpers.
package sr_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SEED   = 2'd0;
  localparam state_t ST_VERIFY = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

  // PRBS7, x^7 + x^6 + 1: prediction is lfsr[6] ^ lfsr[5]
  localparam int unsigned PRBS_LEN = 7;
  localparam int unsigned TAP_HI   = 6;
  localparam int unsigned TAP_LO   = 5;

  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned BIT_CNT_W  = 16;
  localparam int unsigned SEED_CNT_W = 3;

  function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [BIT_CNT_W-1:0] bit_inc(input logic [BIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS7 shift register; shifts in either an external bit (seeding and
// self-synchronising check) or its own prediction (free-running check).
module prbs7_lfsr
  import sr_chk_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic                sel_ext,
  input  logic                ext_bit,
  output logic                pred,
  output logic [PRBS_LEN-1:0] nxt
);

  logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
  logic                in_bit;

  assign pred = lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO];
  assign nxt  = lfsr_d;

  always_comb begin
    in_bit = sel_ext ? ext_bit : pred;
    lfsr_d = lfsr_q;
    if (shift_en) begin
      lfsr_d = {lfsr_q[PRBS_LEN-2:0], in_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/sr_prbs_checker.sv
// PRBS7 checker for a serial bit stream: seeds from the stream, verifies a run
// of correct predictions, then counts bit errors against a free-running LFSR.
module sr_prbs_checker
  import sr_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 16,
  parameter int unsigned WIN       = 64,
  parameter int unsigned LOSS_ERRS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  input  logic                 rx_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [BIT_CNT_W-1:0] bit_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = $clog2(WIN + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_ERRS + 1);

  localparam logic [SEED_CNT_W-1:0] SEED_LAST  = SEED_CNT_W'(PRBS_LEN - 1);
  localparam logic [MATCH_W-1:0]    MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]      WIN_LAST   = WIN_W'(WIN - 1);
  localparam logic [WERR_W-1:0]     WERR_LAST  = WERR_W'(LOSS_ERRS - 1);

  state_t                state_q, state_d;
  logic [SEED_CNT_W-1:0] seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]     win_err_q, win_err_d;
  logic                  locked_q, locked_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [BIT_CNT_W-1:0]  bit_count_q, bit_count_d;

  logic                  pred;
  logic [PRBS_LEN-1:0]   lfsr_nxt;
  logic                  mismatch;
  logic                  sel_ext;

  // Once locked the LFSR free-runs so a corrupted bit cannot poison later predictions
  assign sel_ext = (state_q != ST_LOCKED);

  prbs7_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (rx_valid),
    .sel_ext  (sel_ext),
    .ext_bit  (rx_bit),
    .pred     (pred),
    .nxt      (lfsr_nxt)
  );

  assign mismatch = rx_bit ^ pred;

  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;

    if (rx_valid) begin
      case (state_q)
        ST_SEED: begin
          if (seed_cnt_q == SEED_LAST) begin
            seed_cnt_d = '0;
            // An all-zero seed would lock the LFSR at zero; reseed instead
            if (lfsr_nxt != '0) begin
              state_d     = ST_VERIFY;
              match_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
        ST_VERIFY: begin
          if (mismatch) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
          end else if (match_cnt_q == MATCH_LAST) begin
            state_d   = ST_LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          bit_count_d = bit_inc(bit_count_q);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            err_count_d = err_inc(err_count_q);
          end
          // Loss of lock wins over a window rollover on the same sample
          if (mismatch && (win_err_q == WERR_LAST)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + WERR_W'(mismatch);
          end
        end
        default: begin
          state_d = ST_SEED;
        end
      endcase
    end

    if (clr_cnt) begin
      err_count_d = '0;
      bit_count_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEED;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_sr_prbs_checker.sv
// Bench for sr_prbs_checker: directed lock/loss/saturation sequences, a vector
// table after lock, and random traffic against a queue-based reference model.
module tb_sr_prbs_checker;

  localparam int LOCK_CNT  = 16;
  localparam int WIN       = 64;
  localparam int LOSS_ERRS = 8;

  logic        clk = 1'b0;
  logic        rst, rx_bit, rx_valid, clr_cnt;
  logic        locked, err_pulse;
  logic [7:0]  err_count;
  logic [15:0] bit_count;

  int checks   = 0;
  int failures = 0;

  sr_prbs_checker #(
    .LOCK_CNT  (LOCK_CNT),
    .WIN       (WIN),
    .LOSS_ERRS (LOSS_ERRS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Source stream: s[n] = s[n-7] ^ s[n-6]
  bit [6:0] sg = 7'h7F;
  function automatic bit src_next();
    bit b;
    b  = sg[6] ^ sg[5];
    sg = {sg[5:0], b};
    return b;
  endfunction

  // Reference model: mode 0 seeding, 1 verifying, 2 locked; hist holds the last 7 reference bits
  int m_mode, m_seen, m_run, m_win, m_werr, m_errc, m_bitc;
  bit m_lock, m_pulse;
  bit m_hist[$];

  task automatic m_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit r, input bit v, input bit b, input bit c);
    bit p, e, any;
    if (r) begin
      m_mode = 0; m_seen = 0; m_run = 0; m_win = 0; m_werr = 0;
      m_errc = 0; m_bitc = 0; m_lock = 0; m_pulse = 0;
      m_hist = {};
      for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
      return;
    end
    m_pulse = 0;
    if (v) begin
      p = m_hist[0] ^ m_hist[1];
      if (m_mode == 0) begin
        m_push(b);
        m_seen++;
        if (m_seen == 7) begin
          m_seen = 0;
          any = 0;
          foreach (m_hist[i]) any |= m_hist[i];
          if (any) begin
            m_mode = 1;
            m_run  = 0;
          end
        end
      end else if (m_mode == 1) begin
        m_push(b);
        if (b != p) begin
          m_mode = 0;
          m_seen = 0;
        end else begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_mode = 2; m_win = 0; m_werr = 0;
          end
        end
      end else begin
        m_push(p);
        e = (b != p);
        if (m_bitc < 65535) m_bitc++;
        if (e && m_errc < 255) m_errc++;
        m_pulse = e;
        m_win++;
        m_werr += int'(e);
        if (m_werr == LOSS_ERRS) begin
          m_mode = 0; m_seen = 0; m_win = 0; m_werr = 0;
        end else if (m_win == WIN) begin
          m_win = 0; m_werr = 0;
        end
      end
    end
    if (c) begin
      m_errc = 0;
      m_bitc = 0;
    end
    m_lock = (m_mode == 2);
  endtask

  task automatic cyc(input bit r, input bit v, input bit b, input bit c);
    rst = r; rx_valid = v; rx_bit = b; clr_cnt = c;
    @(posedge clk);
    model_step(r, v, b, c);
    #1;
    check("mdl_locked", 32'(locked), 32'(m_lock));
    check("mdl_err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("mdl_err_count", 32'(err_count), 32'(m_errc));
    check("mdl_bit_count", 32'(bit_count), 32'(m_bitc));
  endtask

  task automatic sample(input bit v, input bit inv, input bit c);
    bit b;
    if (v) b = src_next() ^ inv;
    else   b = 1'($urandom);
    cyc(1'b0, v, b, c);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lock_up();
    for (int i = 0; i < LOCK_CNT + 7; i++) sample(1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit v; bit inv; bit c;
    bit e_lock; bit e_pulse; int e_err; int e_bits;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit saw;
    int burst;

    tbl[0] = '{1, 0, 0, 1, 0, 0, 1};
    tbl[1] = '{1, 1, 0, 1, 1, 1, 2};
    tbl[2] = '{0, 1, 0, 1, 0, 1, 2};
    tbl[3] = '{1, 0, 0, 1, 0, 1, 3};
    tbl[4] = '{1, 1, 1, 1, 1, 0, 0};
    tbl[5] = '{1, 1, 0, 1, 1, 1, 1};
    tbl[6] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 0, 0, 1};

    // Reset state
    do_reset();
    do_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_bit_count", 32'(bit_count), 0);

    // Lock on sample 23
    for (int i = 1; i <= 23; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      if (i == 22) check("lock_before_23", 32'(locked), 0);
    end
    check("lock_at_23", 32'(locked), 1);
    check("lock_err_count", 32'(err_count), 0);

    // Vector table from a fresh lock
    foreach (tbl[i]) begin
      sample(tbl[i].v, tbl[i].inv, tbl[i].c);
      check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].e_lock));
      check($sformatf("tbl%0d_err_pulse", i), 32'(err_pulse), 32'(tbl[i].e_pulse));
      check($sformatf("tbl%0d_err_count", i), 32'(err_count), tbl[i].e_err);
      check($sformatf("tbl%0d_bit_count", i), 32'(bit_count), tbl[i].e_bits);
    end
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      saw |= err_pulse;
    end
    check("no_err_after_single", 32'(saw), 0);

    // Eight errors in a window drop lock; re-lock 23 samples later
    do_reset();
    lock_up();
    for (int i = 1; i <= 8; i++) begin
      sample(1'b1, 1'b1, 1'b0);
      if (i == 7) check("loss_hold_7", 32'(locked), 1);
    end
    check("loss_at_8", 32'(locked), 0);
    check("loss_err_count", 32'(err_count), 8);
    for (int i = 1; i <= 23; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      if (i == 22) check("relock_before_23", 32'(locked), 0);
    end
    check("relock_at_23", 32'(locked), 1);

    // All-zero stream never locks
    do_reset();
    saw = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      saw |= locked;
    end
    check("zeros_never_lock", 32'(saw), 0);
    check("zeros_err_count", 32'(err_count), 0);

    // Error counter saturation, then clear on an error cycle
    do_reset();
    lock_up();
    for (int k = 0; k < 3000; k++) sample(1'b1, (k % 10) == 9, 1'b0);
    check("sat_err_count", 32'(err_count), 255);
    check("sat_locked", 32'(locked), 1);
    sample(1'b1, 1'b1, 1'b1);
    check("clr_err_count", 32'(err_count), 0);
    check("clr_bit_count", 32'(bit_count), 0);
    check("clr_err_pulse", 32'(err_pulse), 1);

    // Half-rate valid: lock after 46 cycles, then reset while locked
    do_reset();
    for (int k = 1; k <= 46; k++) begin
      sample((k % 2) == 0, 1'b0, 1'b0);
      if (k == 45) check("half_before_46", 32'(locked), 0);
    end
    check("half_at_46", 32'(locked), 1);
    for (int k = 1; k <= 10; k++) sample((k % 2) == 0, k == 4, 1'b0);
    check("half_err_count", 32'(err_count), 1);
    cyc(1'b1, 1'b1, src_next() ^ 1'b1, 1'b0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_err_pulse", 32'(err_pulse), 0);
    check("midrst_err_count", 32'(err_count), 0);
    check("midrst_bit_count", 32'(bit_count), 0);
    saw = 0;
    for (int i = 0; i < 60; i++) begin
      sample(1'b1, 1'b1, 1'b0);
      saw |= err_pulse | locked;
    end
    check("postrst_quiet", 32'(saw), 0);
    check("postrst_err_count", 32'(err_count), 0);

    // Random traffic against the model
    do_reset();
    burst = 0;
    for (int i = 0; i < 4000 && failures < 40; i++) begin
      bit r, v, inv, c;
      if ($urandom_range(0, 499) == 0) burst = $urandom_range(4, 12);
      r   = ($urandom_range(0, 999) == 0);
      v   = ($urandom_range(0, 3) != 0);
      inv = (burst > 0) || ($urandom_range(0, 39) == 0);
      c   = ($urandom_range(0, 149) == 0);
      if (burst > 0 && v) burst--;
      if (r) cyc(1'b1, v, 1'($urandom), c);
      else   sample(v, inv, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
